// File: rtl/seq_divider_8bit_pkg.sv
// Shared ALU definitions for the sequential divider: FSM state encoding and
// the default operand width.
package seq_divider_8bit_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/subtractor_nbit.sv
// Parameterised ripple-borrow subtractor, diff_o = a_i - b_i, with borrow-out.
// Shaped like the ALU ripple adders so the subtract path can reuse it.
module subtractor_nbit #(
    parameter int N = 9
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] diff_o,
    output logic         borrow_o
);

    logic borrow_chain;

    // NOTE: blocking assignments are correct here; borrow_chain is a
    // combinational temporary that each loop iteration reads back in order.
    always_comb begin
        diff_o       = '0;
        borrow_chain = 1'b0;
        for (int i = 0; i < N; i++) begin
            diff_o[i]    = a_i[i] ^ b_i[i] ^ borrow_chain;
            borrow_chain = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & borrow_chain);
        end
        borrow_o = borrow_chain;
    end

endmodule

// File: rtl/seq_divider_8bit.sv
// Multi-cycle unsigned restoring divider with start/busy/done handshake.
// One trial subtraction per clock, dividend consumed MSB first.
module seq_divider_8bit
    import seq_divider_8bit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   dividend_q, dividend_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic [WIDTH:0]     partial_q, partial_d;
    logic [WIDTH-1:0]   quo_sr_q, quo_sr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;
    logic               borrow;

    // The dividend register shifts left each iteration, so its MSB is always
    // the next bit to bring into the partial remainder.
    assign shifted = (partial_q << 1) | {{WIDTH{1'b0}}, dividend_q[WIDTH-1]};

    subtractor_nbit #(
        .N (WIDTH + 1)
    ) u_trial_sub (
        .a_i      (shifted),
        .b_i      ({1'b0, divisor_q}),
        .diff_o   (trial),
        .borrow_o (borrow)
    );

    // NOTE: every variable is given its hold value first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        partial_d   = partial_q;
        quo_sr_d    = quo_sr_q;
        count_d     = count_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    dividend_d = dividend;
                    divisor_d  = divisor;
                    partial_d  = '0;
                    quo_sr_d   = '0;
                    count_d    = '0;
                    if (divisor == '0) begin
                        state_d     = DONE;
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = CALC;
                        dbz_d   = 1'b0;
                    end
                end
            end
            CALC: begin
                if (count_q == CNT_W'(WIDTH)) begin
                    state_d     = DONE;
                    quotient_d  = quo_sr_q;
                    remainder_d = partial_q[WIDTH-1:0];
                end else begin
                    partial_d  = borrow ? shifted : trial;
                    quo_sr_d   = {quo_sr_q[WIDTH-2:0], ~borrow};
                    dividend_d = {dividend_q[WIDTH-2:0], 1'b0};
                    count_d    = count_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dividend_q  <= '0;
            divisor_q   <= '0;
            partial_q   <= '0;
            quo_sr_q    <= '0;
            count_q     <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            partial_q   <= partial_d;
            quo_sr_q    <= quo_sr_d;
            count_q     <= count_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
